// File: rtl/ahb3_pkg.sv
// rtl/ahb3_pkg.sv - AHB3-Lite encodings and slave state type
package ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb3_be_gen.sv
// rtl/ahb3_be_gen.sv - byte-enable and size/alignment check from hsize and address low bits
// Ports:
//   hsize    in   transfer size (log2 of bytes)
//   addr_lo  in   byte offset within the data word
//   be       out  little-endian byte-lane enables
//   size_ok  out  transfer size fits in the data bus
//   align_ok out  address is aligned to the transfer size
module ahb3_be_gen #(
    parameter  int HDATA_SIZE = 32,
    localparam int NBYTES     = HDATA_SIZE / 8,
    localparam int ADDR_LSB   = $clog2(NBYTES)
) (
    input  logic [2:0]          hsize,
    input  logic [ADDR_LSB-1:0] addr_lo,
    output logic [NBYTES-1:0]   be,
    output logic                size_ok,
    output logic                align_ok
);

    int nbytes;

    always_comb begin
        nbytes   = 1 << hsize;
        size_ok  = (int'(hsize) <= ADDR_LSB);
        align_ok = ((int'(addr_lo) & (nbytes - 1)) == 0);
        // Lanes are only meaningful for legal accesses; illegal ones never write.
        for (int i = 0; i < NBYTES; i++) begin
            be[i] = (i >= int'(addr_lo)) && (i < int'(addr_lo) + nbytes);
        end
    end

endmodule

// File: rtl/ahb3_slave_mem.sv
// rtl/ahb3_slave_mem.sv - AHB3-Lite slave with word-organised memory, wait states and ERROR response
// Ports:
//   hclk, hrst          clock, asynchronous active-low reset
//   hsel, htrans, hready address-phase qualification
//   haddr, hwrite, hsize address-phase control, latched at acceptance
//   hburst, hprot, hmastlock accepted and ignored
//   hwdata              write data (data phase)
//   hrdata              read data (data phase), zero otherwise
//   hreadyout, hresp    slave ready and response
module ahb3_slave_mem
    import ahb3_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hrst,
    input  logic                  hsel,
    input  logic [HADDR_SIZE-1:0] haddr,
    input  logic [HDATA_SIZE-1:0] hwdata,
    output logic [HDATA_SIZE-1:0] hrdata,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [1:0]            htrans,
    input  logic                  hmastlock,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int         NBYTES    = HDATA_SIZE / 8;
    localparam int         ADDR_LSB  = $clog2(NBYTES);
    localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    state_t                state;
    logic [3:0]            wcnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic [NBYTES-1:0]     be_q;

    logic [HADDR_SIZE-1:0] word_idx;
    logic [NBYTES-1:0]     be;
    logic                  size_ok;
    logic                  align_ok;
    logic                  legal;
    logic                  can_accept;
    logic                  accept;
    logic                  complete;
    logic                  unused;

    assign unused = ^{hburst, hprot, hmastlock};

    ahb3_be_gen #(.HDATA_SIZE(HDATA_SIZE)) u_be_gen (
        .hsize    (hsize),
        .addr_lo  (haddr[ADDR_LSB-1:0]),
        .be       (be),
        .size_ok  (size_ok),
        .align_ok (align_ok)
    );

    assign word_idx = haddr >> ADDR_LSB;
    assign legal    = (word_idx < HADDR_SIZE'(MEM_DEPTH)) && size_ok && align_ok;

    // A new address phase is only taken when no data phase is stalling the bus.
    assign can_accept = (state == ST_IDLE) || (state == ST_ERR2) ||
                        ((state == ST_DATA) && (wcnt == 4'd0));
    assign accept     = can_accept && hsel && hready &&
                        ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign complete   = (state == ST_DATA) && (wcnt == 4'd0);

    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            state     <= ST_IDLE;
            wcnt      <= 4'd0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            be_q      <= '0;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
        end else if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            hreadyout <= 1'b1;
            hresp     <= HRESP_ERROR;
        end else if ((state == ST_DATA) && (wcnt != 4'd0)) begin
            wcnt      <= wcnt - 4'd1;
            hreadyout <= (wcnt == 4'd1);
        end else if (accept) begin
            idx_q <= word_idx[IDX_W-1:0];
            wr_q  <= hwrite;
            be_q  <= be;
            if (legal) begin
                state     <= ST_DATA;
                wcnt      <= WAIT_INIT;
                hreadyout <= (WAIT_INIT == 4'd0);
                hresp     <= HRESP_OKAY;
            end else begin
                state     <= ST_ERR1;
                wcnt      <= 4'd0;
                hreadyout <= 1'b0;
                hresp     <= HRESP_ERROR;
            end
        end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
        end
    end

    // Commit on the edge that ends the completing data phase; a reset in flight
    // forces state to IDLE so the write is dropped.
    always_ff @(posedge hclk) begin
        if (complete && wr_q) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if ((state == ST_DATA) && !wr_q) begin
            hrdata = mem[idx_q];
        end
    end

endmodule

// File: tb/tb_ahb3_slave_mem.sv
// tb/tb_ahb3_slave_mem.sv - self-checking bench for ahb3_slave_mem
module tb_ahb3_slave_mem;
    import ahb3_pkg::*;

    logic        hclk = 1'b0;
    logic        hrst;
    logic        hsel_bus;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        block;
    int          cur;

    logic [2:0]        rdy_v;
    logic [2:0]        resp_v;
    logic [2:0][31:0]  rdata_v;

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        ahb3_slave_mem #(
            .HADDR_SIZE  (32),
            .HDATA_SIZE  (32),
            .MEM_DEPTH   (256),
            .WAIT_STATES (WS)
        ) u_dut (
            .hclk      (hclk),
            .hrst      (hrst),
            .hsel      (hsel_bus && (cur == g)),
            .haddr     (haddr),
            .hwdata    (hwdata),
            .hrdata    (rdata_v[g]),
            .hwrite    (hwrite),
            .hsize     (hsize),
            .hburst    (hburst),
            .hprot     (hprot),
            .htrans    (htrans),
            .hmastlock (hmastlock),
            .hready    (rdy_v[g] & ~block),
            .hreadyout (rdy_v[g]),
            .hresp     (resp_v[g])
        );
    end

    typedef struct {
        int          inst;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          id;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        logic [31:0] wdata;
        int          waits;
    } exp_t;

    vec_t vecs[$];

    function automatic int ws_of(input int inst);
        return (inst == 0) ? 0 : ((inst == 1) ? 2 : 3);
    endfunction

    function automatic vec_t mk(input int inst, input logic [1:0] trans, input logic wr,
                                input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic err, input logic chk,
                                input logic [31:0] rdata);
        vec_t v;
        v.inst = inst; v.trans = trans; v.wr = wr; v.addr = addr; v.size = size;
        v.wdata = wdata; v.err = err; v.chk = chk; v.rdata = rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pipelined master: address of the next vector overlaps the data phase of the
    // previous one. Expectations are queued at acceptance and popped at completion.
    task automatic run_vecs(input int first, input int n);
        exp_t q[$];
        exp_t e;
        int   ai    = first;
        int   waits = 0;
        int   cyc   = 0;
        logic rdy;
        cur = vecs[first].inst;
        while (((ai < first + n) || (q.size() > 0)) && (cyc < 300)) begin
            if (ai < first + n) begin
                hsel_bus = 1'b1;
                htrans   = vecs[ai].trans;
                haddr    = vecs[ai].addr;
                hwrite   = vecs[ai].wr;
                hsize    = vecs[ai].size;
            end else begin
                hsel_bus = 1'b0;
                htrans   = HTRANS_IDLE;
            end
            hwdata = (q.size() > 0) ? q[0].wdata : 32'h0;
            @(negedge hclk);
            rdy = rdy_v[cur];
            if (q.size() > 0) begin
                check($sformatf("hresp v%0d", q[0].id), 32'(resp_v[cur]), 32'(q[0].err));
                if (rdy) begin
                    e = q.pop_front();
                    check($sformatf("waits v%0d", e.id), 32'(waits), 32'(e.waits));
                    if (e.chk) check($sformatf("hrdata v%0d", e.id), rdata_v[cur], e.rdata);
                    waits = 0;
                end else begin
                    waits++;
                end
            end
            @(posedge hclk);
            #1;
            if (rdy && (ai < first + n)) begin
                e.id    = ai;
                e.err   = vecs[ai].err;
                e.chk   = vecs[ai].chk;
                e.rdata = vecs[ai].rdata;
                e.wdata = vecs[ai].wdata;
                e.waits = vecs[ai].err ? 1 : ws_of(vecs[ai].inst);
                q.push_back(e);
                ai++;
            end
            cyc++;
        end
        hsel_bus = 1'b0;
        htrans   = HTRANS_IDLE;
        if (cyc >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout run_vecs first=%0d: got %0d cycles expected < 300", first, cyc);
        end
    endtask

    localparam logic [1:0] NS = HTRANS_NONSEQ;
    localparam logic [1:0] SQ = HTRANS_SEQ;

    initial begin
        hrst = 1'b0; block = 1'b0; hsel_bus = 1'b0; htrans = HTRANS_IDLE;
        haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = HSIZE_WORD;
        hburst = '0; hprot = '0; hmastlock = 1'b0; cur = 0;

        // Instance 0: zero wait states, index 0..14
        vecs.push_back(mk(0, NS, 1, 32'h40,  HSIZE_WORD,  32'hDEADBEEF, 0, 1, 32'h0));
        vecs.push_back(mk(0, NS, 0, 32'h40,  HSIZE_WORD,  32'h0,        0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, NS, 1, 32'h41,  HSIZE_BYTE,  32'h0000AB00, 0, 1, 32'h0));
        vecs.push_back(mk(0, NS, 0, 32'h40,  HSIZE_WORD,  32'h0,        0, 1, 32'hDEADABEF));
        vecs.push_back(mk(0, NS, 0, 32'h400, HSIZE_WORD,  32'h0,        1, 1, 32'h0));
        vecs.push_back(mk(0, NS, 1, 32'h42,  HSIZE_WORD,  32'h11111111, 1, 1, 32'h0));
        vecs.push_back(mk(0, NS, 0, 32'h40,  HSIZE_WORD,  32'h0,        0, 1, 32'hDEADABEF));
        vecs.push_back(mk(0, NS, 1, 32'h80,  HSIZE_WORD,  32'h12345678, 0, 1, 32'h0));
        vecs.push_back(mk(0, NS, 0, 32'h80,  HSIZE_WORD,  32'h0,        0, 1, 32'h12345678));
        vecs.push_back(mk(0, NS, 1, 32'h82,  HSIZE_HWORD, 32'hCAFE0000, 0, 1, 32'h0));
        vecs.push_back(mk(0, NS, 0, 32'h80,  HSIZE_WORD,  32'h0,        0, 1, 32'hCAFE5678));
        vecs.push_back(mk(0, NS, 0, 32'h40,  HSIZE_DWORD, 32'h0,        1, 1, 32'h0));
        vecs.push_back(mk(0, NS, 1, 32'h41,  HSIZE_HWORD, 32'h22222222, 1, 1, 32'h0));
        vecs.push_back(mk(0, NS, 1, 32'h3FC, HSIZE_WORD,  32'hA5A5A5A5, 0, 1, 32'h0));
        vecs.push_back(mk(0, NS, 0, 32'h3FC, HSIZE_WORD,  32'h0,        0, 1, 32'hA5A5A5A5));
        // Instance 1: two wait states, index 15..18
        vecs.push_back(mk(1, NS, 1, 32'h10,  HSIZE_WORD,  32'hAAAA5555, 0, 1, 32'h0));
        vecs.push_back(mk(1, SQ, 1, 32'h14,  HSIZE_WORD,  32'h12121212, 0, 1, 32'h0));
        vecs.push_back(mk(1, NS, 0, 32'h10,  HSIZE_WORD,  32'h0,        0, 1, 32'hAAAA5555));
        vecs.push_back(mk(1, SQ, 0, 32'h14,  HSIZE_WORD,  32'h0,        0, 1, 32'h12121212));
        // Instance 2: three wait states, index 19..21
        vecs.push_back(mk(2, NS, 1, 32'h84,  HSIZE_WORD,  32'h0BADF00D, 0, 1, 32'h0));
        vecs.push_back(mk(2, NS, 0, 32'h84,  HSIZE_WORD,  32'h0,        0, 1, 32'h0BADF00D));
        vecs.push_back(mk(2, NS, 0, 32'h84,  HSIZE_WORD,  32'h0,        0, 1, 32'h0BADF00D));

        repeat (2) @(posedge hclk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset hreadyout i%0d", g), 32'(rdy_v[g]), 32'h1);
            check($sformatf("reset hresp i%0d", g), 32'(resp_v[g]), 32'h0);
            check($sformatf("reset hrdata i%0d", g), rdata_v[g], 32'h0);
        end
        hrst = 1'b1;
        @(posedge hclk);
        #1;

        run_vecs(0, 15);

        // hready held low by another slave: the address phase must be ignored.
        cur = 0; block = 1'b1;
        hsel_bus = 1'b1; htrans = NS; haddr = 32'h80; hwrite = 1'b0; hsize = HSIZE_WORD;
        @(posedge hclk);
        #1;
        hsel_bus = 1'b0; htrans = HTRANS_IDLE; block = 1'b0;
        @(negedge hclk);
        check("blocked hreadyout", 32'(rdy_v[0]), 32'h1);
        check("blocked hrdata", rdata_v[0], 32'h0);
        @(posedge hclk);
        #1;

        run_vecs(15, 4);
        run_vecs(19, 2);

        // Reset during the second wait cycle of a write to 0x84.
        cur = 2;
        hsel_bus = 1'b1; htrans = NS; haddr = 32'h84; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk);
        #1;
        hsel_bus = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
        check("rst wait1 hreadyout", 32'(rdy_v[2]), 32'h0);
        @(posedge hclk);
        #1;
        check("rst wait2 hreadyout", 32'(rdy_v[2]), 32'h0);
        #2;
        hrst = 1'b0;
        #1;
        check("rst abort hreadyout", 32'(rdy_v[2]), 32'h1);
        check("rst abort hresp", 32'(resp_v[2]), 32'h0);
        check("rst abort hrdata", rdata_v[2], 32'h0);
        @(posedge hclk);
        #2;
        hrst = 1'b1;
        @(posedge hclk);
        #1;

        run_vecs(21, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb3_slave_mem.md
Name: ahb3_slave_mem

Overview:
- Parametrised AHB3-Lite slave with word-organised internal memory.
- Successor to the fixed 32-bit/256-word slave BFM in the UVM AHB3 bench.
- Adds a true pipelined address/data phase, byte/halfword/word writes via hsize, configurable wait states, and a two-cycle ERROR response for illegal accesses.
- Sits behind the bench's dut_if as the slave-side DUT for master driver and monitor checks.

Parameters:
HADDR_SIZE, 32, address width
HDATA_SIZE, 32, data width; 32 or 64
MEM_DEPTH, 256, number of HDATA_SIZE-bit words
WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY data phase (0..15)

Ports:
hclk  in  1  bus clock, all logic on rising edge
hrst  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  HADDR_SIZE  byte address
hwdata  in  HDATA_SIZE  write data (data phase)
hrdata  out  HDATA_SIZE  read data (data phase)
hwrite  in  1  1=write
hsize  in  3  transfer size
hburst  in  3  accepted, ignored (beats handled individually)
hprot  in  4  accepted, ignored
htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
hmastlock  in  1  accepted, ignored
hready  in  1  bus-wide ready (previous transfer complete)
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR

Behaviour:
- Clock hclk; reset hrst is asynchronous, active-low. Reset values: hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0. Memory contents are not reset (undefined).
- Address phase is accepted on a rising edge when hsel=1, hready=1 and htrans is NONSEQ or SEQ. The slave latches haddr, hwrite and hsize.
- IDLE/BUSY with hsel=1, or hsel=0: zero-wait OKAY, no memory effect.
- Illegal access (checked at acceptance):
  - word index haddr/(HDATA_SIZE/8) >= MEM_DEPTH;
  - hsize > log2(HDATA_SIZE/8);
  - haddr not aligned to hsize.
- States:
  - IDLE: no transfer outstanding. Accepted legal transfer -> DATA (counter=WAIT_STATES). Accepted illegal transfer -> ERR1.
  - DATA: hreadyout=0 while counter>0, decrement each cycle. When counter=0: hreadyout=1, hresp=0, transfer completes this cycle. A new transfer accepted in the same cycle -> DATA/ERR1 (pipelined, no bubble); otherwise -> IDLE.
  - ERR1: hresp=1, hreadyout=0 -> ERR2.
  - ERR2: hresp=1, hreadyout=1. Any address phase presented in this cycle is accepted exactly as in IDLE (master may cancel by driving IDLE).
- Write: byte lanes enabled from latched hsize and haddr low bits, little-endian. mem is updated on the rising edge ending the completing data-phase cycle (hreadyout=1) using hwdata lanes. Disabled lanes are unchanged. Errored writes never modify memory.
- Read: hrdata = mem[latched index] during DATA while the transfer is a read, all lanes returned. Otherwise hrdata=0. Errored reads return 0.
- Write-then-read of the same word back-to-back: the read returns the new data (write commits on the edge that starts the read data phase).
- Reset mid-transfer: aborts immediately, pending write is not committed, outputs return to reset values.
- hready=0 from another slave: no acceptance; the slave holds its current state.

Decomposition:
- ahb3_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE_BYTE/HWORD/WORD/DWORD;
  - HRESP_OKAY/ERROR;
  - state enum {IDLE, DATA, ERR1, ERR2}.
- One sub-module: ahb3_be_gen — combinational byte-enable and alignment-check generator from (hsize, haddr low bits), parametrised on HDATA_SIZE.

Test Plan:
- Defaults. Write NONSEQ word 0xDEADBEEF at haddr 0x40, then read 0x40 -> OKAY both, hreadyout never low, hrdata=0xDEADBEEF in the read data phase.
- After the above, byte write hsize=0, haddr 0x41, hwdata 0x0000AB00; read 0x40 -> 0xDEADABEF.
- WAIT_STATES=2. Single read -> hreadyout low exactly 2 cycles then high with data. Back-to-back SEQ reads -> 2 waits per beat, no extra bubble.
- Read haddr 0x400 (index 256) -> ERR1 (hresp=1, hreadyout=0) then ERR2 (hresp=1, hreadyout=1). Write haddr 0x42, hsize=2 (misaligned) -> same 2-cycle ERROR, mem[0x10] unchanged.
- Write 0x12345678 to 0x80 immediately followed by read 0x80, zero wait -> read data 0x12345678.
- WAIT_STATES=3. Assert hrst low during the 2nd wait cycle of a write to 0x84 -> hreadyout=1, hresp=0, hrdata=0 at once. Later read of 0x84 shows the previously written value (write not committed).
